tdm_demux16: RTL
================

# tdm_demux16

Sequential 1-to-16 time-division demultiplexer: the receive end of the 16-slot serial lane produced by scanning a 16:1 mux select from 0 to 15. A serial bit stream with a frame marker enters the block. Each valid bit is steered into bit position `slot` of a 16-bit word, and the completed word is presented in parallel with a one-cycle valid pulse. The block sits between the serial link and any parallel consumer. Convention: slot k maps to `dout[k]`, matching mux select k choosing `in[k]`.

## Interface
Parameters:
- None. The slot count is fixed at 16.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `din`  in  1  serial data bit
- `din_valid`  in  1  `din` and `frame_start` are sampled only when this is 1
- `frame_start`  in  1  qualified by `din_valid`; marks the current bit as slot 0
- `dout`  out  16  last completed frame; `dout[k]` is slot k
- `dout_valid`  out  1  one-cycle pulse when `dout` is updated
- `slot`  out  4  index that the next accepted bit in RECV will be written to
- `busy`  out  1  1 while in RECV
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by an early `frame_start`

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Internal state: a 16-bit shadow register, a 4-bit slot counter, and a 2-state FSM with states IDLE and RECV.
- Accepted sample: `din_valid`=1. Cycles with `din_valid`=0 change nothing, in both states.
- IDLE:
  - Accepted sample with `frame_start`=1: write `shadow[0]`=`din`, set `slot`=1, go to RECV.
  - Accepted sample with `frame_start`=0: discard the bit and stay in IDLE.
- RECV, accepted sample with `frame_start`=0:
  - Write `shadow[slot]`=`din`, then increment `slot`.
  - If `slot` was 15: load `dout` with the full shadow word, including bit 15 taken directly from `din`. Pulse `dout_valid`, set `slot`=0, go to IDLE.
- RECV, accepted sample with `frame_start`=1, for any slot 1..15:
  - Pulse `frame_err` and discard the partial frame; `dout` is unchanged.
  - Restart: write `shadow[0]`=`din`, set `slot`=1, stay in RECV.
- Back-to-back frames: the slot-15 bit of frame N and the slot-0 bit of frame N+1 arrive on consecutive accepted samples. The block takes no dead cycle: IDLE accepts the `frame_start` on the very next cycle.
- Shadow bits not yet written in the current frame are don't-care. `dout` only ever carries a fully received 16-bit frame.
- `dout` holds its value until the next completed frame.
- `busy` is 1 exactly when the state is RECV.

## Timing
- Reset values (while `rst_n`=0, asynchronously):
  - `dout`=16'h0000, `dout_valid`=0, `frame_err`=0, `slot`=0, `busy`=0
  - state=IDLE, shadow=0
- Latency: `dout` and `dout_valid` are registered. Both update on the rising edge that samples the slot-15 bit and are visible in the following cycle. `dout_valid` is high for exactly one cycle.
- Minimum frame duration: 16 consecutive cycles with `din_valid`=1. Gaps with `din_valid`=0 may appear anywhere; they stretch the frame but do not abort it.
- `frame_err` is registered and pulses one cycle after the offending sample.
- `dout_valid` and `frame_err` are never asserted in the same cycle.
- `slot` and `busy` are registered and reflect state after each edge.
- Reset asserted mid-frame: the partial frame is lost, all outputs return to their reset values immediately, and after release the block waits in IDLE for a `frame_start`.
- No back-pressure: the consumer must capture `dout` on the `dout_valid` pulse or read it before the next frame completes.

## Test plan
- Reset: assert `rst_n`=0 mid-frame at slot 7 -> all outputs read 0 and `busy`=0 immediately. After release, 16 bits with no `frame_start` -> no `dout_valid`.
- Single frame: drive `frame_start` with 16 valid bits of pattern 16'hA5C3 (bit k in slot k) -> `dout`=16'hA5C3 with a `dout_valid` pulse one cycle after the 16th bit; `slot` returns to 0.
- Gapped frame: same pattern with `din_valid`=0 for 3 cycles after slots 4 and 11 -> `dout`=16'hA5C3, no `frame_err`, `dout_valid` 1 cycle after the last bit.
- Back-to-back: frames 16'h1234 then 16'hFFFF with no idle cycles -> two `dout_valid` pulses 16 cycles apart with `dout`=16'h1234 then 16'hFFFF.
- Early `frame_start`: abort at slot 9, then send a complete frame of 16'h8001 -> a `frame_err` pulse, `dout` unchanged until the second frame completes, then `dout`=16'h8001.
- Loopback: a free-running 4-bit counter drives a 16:1 mux select with constant `in`=16'h5A0F, with `frame_start` asserted when the select is 0 -> `dout`=16'h5A0F with a `dout_valid` pulse every 16 cycles.

Source files
------------

// File: rtl/tdm_demux16.sv
// ---------------------------------------------------------------------------
// tdm_demux16
//   Receive end of a 16-slot serial TDM lane. Each accepted bit is written into
//   bit position `slot` of a shadow word. When slot 15 arrives, the complete
//   word is published on `dout` together with a one-cycle `dout_valid` pulse.
//   An early `frame_start` aborts the partial frame, pulses `frame_err` and
//   immediately restarts reception at slot 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   din          serial data bit
//   din_valid    qualifies din / frame_start; cycles with 0 change nothing
//   frame_start  marks the current accepted bit as slot 0
//   dout[15:0]   last completed frame, dout[k] = slot k
//   dout_valid   one-cycle pulse when dout is updated
//   slot[3:0]    slot index that the next accepted bit in RECV is written to
//   busy         1 while receiving a frame (RECV)
//   frame_err    one-cycle pulse when a frame is aborted by an early frame_start
// ---------------------------------------------------------------------------
module tdm_demux16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   input  logic        din_valid,
   input  logic        frame_start,
   output logic [15:0] dout,
   output logic        dout_valid,
   output logic [3:0]  slot,
   output logic        busy,
   output logic        frame_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RECV = 1'b1;

   logic [0:0]  r_state;
   logic [15:0] r_shadow;
   logic [3:0]  r_slot;
   logic [15:0] r_dout;
   logic        r_dout_valid;
   logic        r_frame_err;

   logic        w_last;

   // Slot 15 in RECV closes the frame on this accepted bit.
   assign w_last = (r_state == RECV) && (r_slot == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_shadow     <= '0;
         r_slot       <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (din_valid) begin
            if (frame_start) begin
               // A frame_start while already receiving discards the partial
               // word; either way this bit becomes slot 0 of a new frame.
               if (r_state == RECV) r_frame_err <= 1'b1;
               r_shadow[0] <= din;
               r_slot      <= 4'd1;
               r_state     <= RECV;
            end else if (r_state == RECV) begin
               r_shadow[r_slot] <= din;
               r_slot           <= r_slot + 4'd1;   // wraps 15 -> 0
               if (w_last) begin
                  // Bit 15 bypasses the shadow so the word is published on
                  // this same edge, leaving IDLE ready for a back-to-back frame.
                  r_dout       <= {din, r_shadow[14:0]};
                  r_dout_valid <= 1'b1;
                  r_state      <= IDLE;
               end
            end
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign slot       = r_slot;
   assign busy       = (r_state == RECV);
   assign frame_err  = r_frame_err;

endmodule
